// File: rtl/jam_cost_server.sv
// Cost-query responder for the JAM solver: holds a serially loaded 8x8 cost
// matrix, answers (W,J) lookups and judges the solver's reported result.
module jam_cost_server #(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned TIMEOUT  = 1000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic [3:0]  exp_match_count,
    input  logic [10:0] exp_min_cost,
    input  logic [2:0]  W,
    input  logic [2:0]  J,
    output logic [7:0]  Cost,
    input  logic        Valid,
    input  logic [3:0]  MatchCount,
    input  logic [10:0] MinCost,
    output logic        loaded,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic        protocol_err,
    output logic [15:0] query_count
);

    typedef enum logic [1:0] {IDLE, LOAD, SERVE, DONE} state_t;

    localparam logic [31:0] T_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [5:0]  idx;
    logic [31:0] tcnt;
    logic [3:0]  exp_mc;
    logic [10:0] exp_cost;
    logic [7:0]  mem [64];
    logic [5:0]  addr;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic        done_by_valid;
    logic        done_by_timeout;
    logic        err_set;

    assign addr    = {W, J};
    assign wr_en   = load_valid && (load_start || state == LOAD);
    assign wr_addr = load_start ? 6'd0 : idx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // load_start overrides every state, so it is checked before the case
    always_comb begin
        state_next      = state;
        done_by_valid   = 1'b0;
        done_by_timeout = 1'b0;
        err_set         = Valid && (state == IDLE || state == LOAD);
        if (load_start) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (load_valid && idx == 6'd63) state_next = SERVE;
                end
                SERVE: begin
                    if (Valid) begin
                        state_next    = DONE;
                        done_by_valid = 1'b1;
                    end else if (TIMEOUT != 0 && tcnt == T_LAST) begin
                        state_next      = DONE;
                        done_by_timeout = 1'b1;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= load_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx          <= 6'd0;
            tcnt         <= 32'd0;
            exp_mc       <= 4'd0;
            exp_cost     <= 11'd0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            protocol_err <= 1'b0;
            query_count  <= 16'd0;
        end else begin
            if (err_set) protocol_err <= 1'b1;
            if (load_start) begin
                idx         <= load_valid ? 6'd1 : 6'd0;
                tcnt        <= 32'd0;
                exp_mc      <= exp_match_count;
                exp_cost    <= exp_min_cost;
                pass        <= 1'b0;
                timeout     <= 1'b0;
                query_count <= 16'd0;
            end else begin
                if (state == LOAD && load_valid) idx <= idx + 6'd1;
                tcnt <= (state == SERVE) ? tcnt + 32'd1 : 32'd0;
                if (state == SERVE && query_count != 16'hFFFF)
                    query_count <= query_count + 16'd1;
                if (done_by_valid)
                    pass <= (MatchCount == exp_mc) && (MinCost == exp_cost);
                if (done_by_timeout) begin
                    timeout <= 1'b1;
                    pass    <= 1'b0;
                end
            end
        end
    end

    assign loaded = (state == SERVE);
    assign done   = (state == DONE);

    generate
        if (READ_LAT == 0) begin : g_comb
            assign Cost = (state == SERVE) ? mem[addr] : 8'd0;
        end else begin : g_reg
            logic [7:0] cost_q;
            // gated on the next state so Cost reads 0 from the first non-SERVE cycle
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) cost_q <= 8'd0;
                else     cost_q <= (state_next == SERVE) ? mem[addr] : 8'd0;
            end
            assign Cost = cost_q;
        end
    endgenerate

endmodule
